// File: rtl/instr_decode_stage.sv
// Instruction decode stage: field split and immediate extension,
// buffered by a two-entry (main + skid) valid/ready pipeline register.
package instr_decode_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic        use_imm;
        logic [4:0]  wr_reg;
    } dec_t;
endpackage

module instr_decode_stage
    import instr_decode_pkg::*;
#(
    parameter bit SIGN_EXT_LOGIC = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [5:0]  out_opcode,
    output logic [5:0]  out_funct,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_shamt,
    output logic [31:0] out_imm,
    output logic        out_use_imm,
    output logic [4:0]  out_wr_reg
);

    dec_t dec;
    dec_t main_q;
    dec_t skid_q;
    logic main_valid;
    logic skid_valid;
    logic is_rtype;
    logic is_arith;
    logic is_logic;
    logic accept;
    logic drain;

    assign is_rtype = (in_instr[31:26] == 6'b000000);
    assign is_arith = (in_instr[31:26] == 6'b001000)
                   || (in_instr[31:26] == 6'b001010)
                   || (in_instr[31:26] == 6'b001011);
    assign is_logic = (in_instr[31:26] == 6'b001100)
                   || (in_instr[31:26] == 6'b001101)
                   || (in_instr[31:26] == 6'b001110);

    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.opcode  = in_instr[31:26];
        dec.rs      = in_instr[25:21];
        dec.rt      = in_instr[20:16];
        dec.rd      = in_instr[15:11];
        dec.shamt   = in_instr[10:6];
        dec.funct   = in_instr[5:0];
        dec.imm     = {{16{in_instr[15]}}, in_instr[15:0]};
        dec.use_imm = 1'b0;
        dec.wr_reg  = in_instr[20:16];
        unique case (1'b1)
            is_rtype: dec.wr_reg = in_instr[15:11];
            is_arith: dec.use_imm = 1'b1;
            is_logic: begin
                dec.use_imm = 1'b1;
                if (!SIGN_EXT_LOGIC)
                    dec.imm = {16'h0000, in_instr[15:0]};
            end
            default: ;
        endcase
    end

    // skid_valid is a flop, so in_ready is registered by construction
    assign in_ready = ~skid_valid;
    assign accept   = in_valid && in_ready;
    assign drain    = main_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (drain) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid || drain) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end
        end else if (drain) begin
            main_valid <= 1'b0;
        end
    end

    assign out_valid   = main_valid;
    assign out_pc      = main_q.pc;
    assign out_opcode  = main_q.opcode;
    assign out_funct   = main_q.funct;
    assign out_rs      = main_q.rs;
    assign out_rt      = main_q.rt;
    assign out_rd      = main_q.rd;
    assign out_shamt   = main_q.shamt;
    assign out_imm     = main_q.imm;
    assign out_use_imm = main_q.use_imm;
    assign out_wr_reg  = main_q.wr_reg;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed scenarios plus a randomized
// run against a queue model, for both immediate-extension variants.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;

    logic        rdy  [2];
    logic        vld  [2];
    logic [31:0] o_pc [2];
    logic [5:0]  o_op [2];
    logic [5:0]  o_fn [2];
    logic [4:0]  o_rs [2];
    logic [4:0]  o_rt [2];
    logic [4:0]  o_rd [2];
    logic [4:0]  o_sh [2];
    logic [31:0] o_imm[2];
    logic        o_ui [2];
    logic [4:0]  o_wr [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_decode_stage #(.SIGN_EXT_LOGIC(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy[0]),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(vld[0]), .out_ready(out_ready),
        .out_pc(o_pc[0]), .out_opcode(o_op[0]), .out_funct(o_fn[0]),
        .out_rs(o_rs[0]), .out_rt(o_rt[0]), .out_rd(o_rd[0]),
        .out_shamt(o_sh[0]), .out_imm(o_imm[0]),
        .out_use_imm(o_ui[0]), .out_wr_reg(o_wr[0])
    );

    instr_decode_stage #(.SIGN_EXT_LOGIC(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy[1]),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(vld[1]), .out_ready(out_ready),
        .out_pc(o_pc[1]), .out_opcode(o_op[1]), .out_funct(o_fn[1]),
        .out_rs(o_rs[1]), .out_rt(o_rt[1]), .out_rd(o_rd[1]),
        .out_shamt(o_sh[1]), .out_imm(o_imm[1]),
        .out_use_imm(o_ui[1]), .out_wr_reg(o_wr[1])
    );

    function automatic logic [101:0] obs(input int k);
        return {o_pc[k], o_op[k], o_fn[k], o_rs[k], o_rt[k],
                o_rd[k], o_sh[k], o_imm[k], o_ui[k], o_wr[k]};
    endfunction

    // Reference decode straight from the opcode table
    function automatic logic [101:0] expv(input logic [31:0] pc,
                                          input logic [31:0] ins,
                                          input bit sx);
        int unsigned op;
        logic ui;
        logic [4:0] wr;
        logic [31:0] imm;
        op  = ins >> 26;
        ui  = (op == 8 || op == 10 || op == 11 ||
               op == 12 || op == 13 || op == 14);
        wr  = (op == 0) ? ins[15:11] : ins[20:16];
        if (op >= 12 && op <= 14 && !sx)
            imm = ins & 32'h0000FFFF;
        else
            imm = 32'($signed(ins[15:0]));
        return {pc, ins[31:26], ins[5:0], ins[25:21], ins[20:16],
                ins[15:11], ins[10:6], imm, ui, wr};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (vld[k] !== 1'b0 || obs(k) !== '0) begin
                failures++;
                $display("FAIL reset_state dut%0d valid=%b data=%h want 0",
                         k, vld[k], obs(k));
            end
        end
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rdy[k] !== 1'b1 || vld[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_release dut%0d ready=%b valid=%b want 1/0",
                         k, rdy[k], vld[k]);
            end
        end
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h2109FFFC;
        in_pc = 32'h0000_0100;
        step();
        in_valid = 1'b0;
        checks++;
        if ({vld[0], o_op[0], o_rs[0], o_rt[0], o_imm[0], o_ui[0], o_wr[0]}
            !== {1'b1, 6'b001000, 5'd8, 5'd9, 32'hFFFFFFFC, 1'b1, 5'd9}) begin
            failures++;
            $display("FAIL addi got op=%b rs=%0d rt=%0d imm=%h ui=%b wr=%0d",
                     o_op[0], o_rs[0], o_rt[0], o_imm[0], o_ui[0], o_wr[0]);
        end
        checks++;
        if (obs(1) !== expv(32'h100, 32'h2109FFFC, 1'b1)) begin
            failures++;
            $display("FAIL addi_sx got %h want %h",
                     obs(1), expv(32'h100, 32'h2109FFFC, 1'b1));
        end
        step();
        checks++;
        if (vld[0] !== 1'b0) begin
            failures++;
            $display("FAIL addi_drain valid=%b want 0", vld[0]);
        end
    endtask

    task automatic test_ori();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h35098000;
        in_pc = 32'h0000_0104;
        step();
        in_valid = 1'b0;
        checks++;
        if (o_imm[0] !== 32'h00008000 || o_ui[0] !== 1'b1) begin
            failures++;
            $display("FAIL ori_zext imm=%h ui=%b want 00008000/1",
                     o_imm[0], o_ui[0]);
        end
        checks++;
        if (o_imm[1] !== 32'hFFFF8000 || o_wr[1] !== 5'd9) begin
            failures++;
            $display("FAIL ori_sext imm=%h wr=%0d want ffff8000/9",
                     o_imm[1], o_wr[1]);
        end
        step();
    endtask

    task automatic test_sub();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00221822;
        in_pc = 32'h0000_0108;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({vld[k], o_fn[k], o_rd[k], o_wr[k], o_ui[k]}
                !== {1'b1, 6'b100010, 5'd3, 5'd3, 1'b0}) begin
                failures++;
                $display("FAIL sub dut%0d fn=%b rd=%0d wr=%0d ui=%b",
                         k, o_fn[k], o_rd[k], o_wr[k], o_ui[k]);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        a = 32'h20020005;
        b = 32'h34431234;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = a;
        in_pc = 32'h200;
        step();
        in_instr = b;
        in_pc = 32'h204;
        step();
        in_valid = 1'b0;
        repeat (2) begin
            checks++;
            if (vld[0] !== 1'b1 || rdy[0] !== 1'b0 ||
                obs(0) !== expv(32'h200, a, 1'b0)) begin
                failures++;
                $display("FAIL b2b_hold_a valid=%b ready=%b got %h want %h",
                         vld[0], rdy[0], obs(0), expv(32'h200, a, 1'b0));
            end
            step();
        end
        out_ready = 1'b1;
        checks++;
        if (obs(0) !== expv(32'h200, a, 1'b0)) begin
            failures++;
            $display("FAIL b2b_a_out got %h want %h",
                     obs(0), expv(32'h200, a, 1'b0));
        end
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (vld[k] !== 1'b1 || rdy[k] !== 1'b1 ||
                obs(k) !== expv(32'h204, b, k[0])) begin
                failures++;
                $display("FAIL b2b_b_out dut%0d valid=%b ready=%b got %h want %h",
                         k, vld[k], rdy[k], obs(k), expv(32'h204, b, k[0]));
            end
        end
        step();
        checks++;
        if (vld[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain valid=%b want 0", vld[0]);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h2108_0001;
        in_pc = 32'h300;
        step();
        in_pc = 32'h304;
        step();
        in_pc = 32'h308;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (vld[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            failures++;
            $display("FAIL flush_clear valid=%b ready=%b want 0/1",
                     vld[0], rdy[0]);
        end
        out_ready = 1'b1;
        repeat (3) begin
            step();
            checks++;
            if (vld[0] !== 1'b0) begin
                failures++;
                $display("FAIL flush_ghost valid=%b pc=%h want 0",
                         vld[0], o_pc[0]);
            end
        end
        in_valid = 1'b1;
        in_instr = 32'h3109_00FF;
        in_pc = 32'h400;
        step();
        in_valid = 1'b0;
        checks++;
        if (vld[0] !== 1'b1 || obs(0) !== expv(32'h400, 32'h310900FF, 1'b0)) begin
            failures++;
            $display("FAIL flush_after valid=%b got %h want %h", vld[0],
                     obs(0), expv(32'h400, 32'h310900FF, 1'b0));
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h2003_0007;
        in_pc = 32'h500;
        step();
        in_pc = 32'h504;
        step();
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (vld[0] !== 1'b0 || obs(0) !== '0 || rdy[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_async valid=%b ready=%b data=%h want 0/1/0",
                     vld[0], rdy[0], obs(0));
        end
        step();
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h0043_2020;
        in_pc = 32'h600;
        step();
        in_valid = 1'b0;
        checks++;
        if (vld[0] !== 1'b1 || obs(0) !== expv(32'h600, 32'h00432020, 1'b0)) begin
            failures++;
            $display("FAIL reset_first valid=%b got %h want %h", vld[0],
                     obs(0), expv(32'h600, 32'h00432020, 1'b0));
        end
        step();
        checks++;
        if (vld[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_dup valid=%b want 0", vld[0]);
        end
    endtask

    task automatic test_random();
        logic [63:0] q[$];
        int ops[8] = '{0, 8, 10, 11, 12, 13, 14, 0};
        int sel;
        logic [5:0] op;
        bit iv, ordy, fl;
        out_ready = 1'b1;
        in_valid = 1'b0;
        repeat (3) step();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            sel = $urandom_range(0, 7);
            op = (sel == 7) ? 6'($urandom) : 6'(ops[sel]);
            in_instr = {op, 26'($urandom)};
            in_pc = $urandom;
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 99) < 3);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (vld[k] !== (q.size() != 0) || rdy[k] !== (q.size() < 2)) begin
                    failures++;
                    if (failures < 20)
                        $display("FAIL rand_hs cyc=%0d dut%0d valid=%b ready=%b want %b/%b",
                                 cyc, k, vld[k], rdy[k], q.size() != 0, q.size() < 2);
                end
                if (q.size() != 0) begin
                    checks++;
                    if (obs(k) !== expv(q[0][63:32], q[0][31:0], k[0])) begin
                        failures++;
                        if (failures < 20)
                            $display("FAIL rand_data cyc=%0d dut%0d got %h want %h",
                                     cyc, k, obs(k), expv(q[0][63:32], q[0][31:0], k[0]));
                    end
                end
            end
            iv = in_valid;
            ordy = out_ready;
            fl = flush;
            if (fl) begin
                q.delete();
            end else begin
                bit take;
                take = iv && (q.size() < 2);
                if (ordy && q.size() != 0)
                    void'(q.pop_front());
                if (take)
                    q.push_back({in_pc, in_instr});
            end
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_ori();
        test_sub();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
